cn_msg_expand: RTL and testbench

Check-node message expander for the QC-LDPC min-sum decoder. It accepts one compressed check-node record per transaction: min1, min2, the argmin edge index from the minimum-finder tree, and the per-edge sign vector. It then regenerates the N individual check-to-variable messages and emits them serially, one edge per cycle, toward the variable-node update. It is the consumer-side counterpart of the min/index compression.

---
 rtl/cn_msg_expand.sv | 173 +++++++++++++++++
 tb/tb_cn_msg_expand.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cn_msg_expand.sv
// ---------------------------------------------------------------------------
// cn_msg_expand
//
// Check-node message expander for the QC-LDPC min-sum decoder. Takes one
// compressed check-node record (min1, min2, argmin index, per-edge signs)
// and regenerates the N check-to-variable messages, one edge per cycle.
//
// Parameters
//   BITS   : c2v message width (two's complement); magnitudes are BITS-1 bits
//   N      : check-node degree (edges per record), N >= 2
//   IDXW   : width of the edge index fields
//   OFFSET : offset-min-sum correction, subtracted from magnitudes, clamped at 0
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : record valid
//   in_ready   : record accepted on in_valid && in_ready
//   in_min1    : smallest incoming magnitude
//   in_min2    : second-smallest incoming magnitude
//   in_idx     : edge index that produced min1
//   in_sign    : sign of each incoming v2c message (1 = negative)
//   out_valid  : c2v message valid
//   out_ready  : downstream accepts on out_valid && out_ready
//   out_msg    : signed c2v message for edge out_edge
//   out_edge   : edge number 0..N-1
//   out_last   : high with edge N-1
// ---------------------------------------------------------------------------
module cn_msg_expand #(
    parameter int BITS   = 8,
    parameter int N      = 7,
    parameter int IDXW   = $clog2(N),
    parameter int OFFSET = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITS-2:0]        in_min1,
    input  logic [BITS-2:0]        in_min2,
    input  logic [IDXW-1:0]        in_idx,
    input  logic [N-1:0]           in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [BITS-1:0] out_msg,
    output logic [IDXW-1:0]        out_edge,
    output logic                   out_last
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] LAST_EDGE = IDXW'(N - 1);
    localparam logic [BITS-2:0] OFF_MAG   = (BITS - 1)'(OFFSET);

    // Offset correction on an unsigned magnitude, saturating at zero.
    function automatic logic [BITS-2:0] sub_offset(input logic [BITS-2:0] m);
        return (m > OFF_MAG) ? (m - OFF_MAG) : '0;
    endfunction

    // Attach the sign to a magnitude. Magnitude is at most 2^(BITS-1)-1, so
    // negation never overflows, and negating zero yields plain zero.
    function automatic logic signed [BITS-1:0] apply_sign(input logic s,
                                                          input logic [BITS-2:0] mag);
        logic signed [BITS-1:0] v;
        v = signed'({1'b0, mag});
        return s ? -v : v;
    endfunction

    state_t          state_q, state_d;
    logic [IDXW-1:0] cnt_q,   cnt_d;
    logic [BITS-2:0] min1_q,  min1_d;
    logic [BITS-2:0] min2_q,  min2_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [N-1:0]    sign_q,  sign_d;
    logic            par_q,   par_d;

    logic            last_edge;
    logic            out_hs;
    logic            accept;
    logic [BITS-2:0] mag_sel;
    logic [BITS-2:0] mag;
    logic            msg_sign;

    // State and record registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            idx_q   <= '0;
            sign_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            sign_q  <= sign_d;
            par_q   <= par_d;
        end
    end

    // Next-state and record-load logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        sign_d  = sign_q;
        par_d   = par_q;

        out_hs = out_valid && out_ready;
        accept = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXPAND;
                    cnt_d   = '0;
                end
            end
            EXPAND: begin
                if (out_hs) begin
                    if (last_edge) begin
                        cnt_d = '0;
                        // A record accepted alongside the last edge keeps the
                        // expander busy with no bubble.
                        if (!accept) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            min1_d = in_min1;
            min2_d = in_min2;
            idx_d  = in_idx;
            sign_d = in_sign;
            par_d  = ^in_sign;
        end
    end

    // Output logic: everything on out_* comes from registered state only
    always_comb begin
        out_valid = (state_q == EXPAND);
        last_edge = (cnt_q == LAST_EDGE);
        in_ready  = !rst && ((state_q == IDLE) || (out_valid && out_ready && last_edge));

        // An out-of-range idx never matches cnt, so every edge gets min1.
        mag_sel  = (cnt_q == idx_q) ? min2_q : min1_q;
        mag      = sub_offset(mag_sel);
        // Excluding this edge's own sign from the total parity.
        msg_sign = par_q ^ sign_q[cnt_q];

        out_msg  = out_valid ? apply_sign(msg_sign, mag) : '0;
        out_edge = out_valid ? cnt_q : '0;
        out_last = out_valid && last_edge;
    end

endmodule

// File: tb/tb_cn_msg_expand.sv
module tb_cn_msg_expand;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_min1;
    logic [6:0] in_min2;
    logic [2:0] in_idx;
    logic [6:0] in_sign;
    logic       out_ready;

    logic       in_ready0, in_ready2;
    logic       out_valid0, out_valid2;
    logic [7:0] out_msg0, out_msg2;
    logic [2:0] out_edge0, out_edge2;
    logic       out_last0, out_last2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cn_msg_expand #(.BITS(8), .N(7), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_msg(out_msg0), .out_edge(out_edge0), .out_last(out_last0)
    );

    cn_msg_expand #(.BITS(8), .N(7), .OFFSET(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_msg(out_msg2), .out_edge(out_edge2), .out_last(out_last2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [6:0] m1, input logic [6:0] m2,
                        input logic [2:0] ix, input logic [6:0] sg);
        in_min1  = m1;
        in_min2  = m2;
        in_idx   = ix;
        in_sign  = sg;
        in_valid = 1'b1;
    endtask

    // Expected messages are packed {edge6, ..., edge0}; e0 for OFFSET=0, e2 for OFFSET=2.
    task automatic run_record(input string tag,
                              input logic [6:0] m1, input logic [6:0] m2,
                              input logic [2:0] ix, input logic [6:0] sg,
                              input logic [55:0] e0, input logic [55:0] e2);
        load(m1, m2, ix, sg);
        out_ready = 1'b1;
        #1;
        chk({tag, ".rdy0"}, in_ready0, 1);
        chk({tag, ".rdy2"}, in_ready2, 1);
        tick;
        in_valid = 1'b0;
        #1;
        for (int e = 0; e < 7; e++) begin
            chk($sformatf("%s.e%0d.vld", tag, e), out_valid0, 1);
            chk($sformatf("%s.e%0d.vld2", tag, e), out_valid2, 1);
            chk($sformatf("%s.e%0d.edge", tag, e), out_edge0, e);
            chk($sformatf("%s.e%0d.msg", tag, e), out_msg0, e0[8*e +: 8]);
            chk($sformatf("%s.e%0d.msg_off", tag, e), out_msg2, e2[8*e +: 8]);
            chk($sformatf("%s.e%0d.last", tag, e), out_last0, (e == 6));
            chk($sformatf("%s.e%0d.in_rdy", tag, e), in_ready0, (e == 6));
            tick;
        end
        chk({tag, ".done_vld"}, out_valid0, 0);
        chk({tag, ".done_msg"}, out_msg0, 0);
    endtask

    localparam logic [55:0] BASIC_E0 = {8'h03, 8'h03, 8'h03, 8'h03, 8'hF7, 8'h03, 8'hFD};
    localparam logic [55:0] BASIC_E2 = {8'h01, 8'h01, 8'h01, 8'h01, 8'hF9, 8'h01, 8'hFF};
    // 127/127 with only edge 0 negative: edge 0 positive, all others -127 / -125.
    localparam logic [55:0] MAXN_E0  = {8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h7F};
    localparam logic [55:0] MAXN_E2  = {8'h83, 8'h83, 8'h83, 8'h83, 8'h83, 8'h83, 8'h7D};
    localparam logic [55:0] IDX7_E0  = {8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'h04, 8'hFC};
    localparam logic [55:0] IDX7_E2  = {8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h02, 8'hFE};

    initial begin
        logic [3:0]  pat;
        logic [55:0] exp_msg;
        int          e;
        int          k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_min1   = '0;
        in_min2   = '0;
        in_idx    = '0;
        in_sign   = '0;
        out_ready = 1'b0;

        // Reset state
        tick;
        chk("rst.in_ready", in_ready0, 0);
        chk("rst.out_valid", out_valid0, 0);
        chk("rst.out_msg", out_msg0, 0);
        chk("rst.out_edge", out_edge0, 0);
        chk("rst.out_last", out_last0, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst.release_rdy", in_ready0, 1);
        tick;

        // Basic expansion, and the odd-parity record with offset clamping
        run_record("basic", 7'd3, 7'd9, 3'd2, 7'b0000101, BASIC_E0, BASIC_E2);
        run_record("oddpar", 7'd1, 7'd5, 3'd6, 7'b0000001,
                   {8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01},
                   {8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        // Full-scale magnitudes, six negatives seen by every edge: all +127
        run_record("allneg", 7'd127, 7'd127, 3'd0, 7'b1111111,
                   {7{8'h7F}}, {7{8'h7D}});
        run_record("maxneg", 7'd127, 7'd127, 3'd0, 7'b0000001, MAXN_E0, MAXN_E2);
        // Out-of-range index: min2 never used
        run_record("idx7", 7'd4, 7'd50, 3'd7, 7'b0000010, IDX7_E0, IDX7_E2);

        // Backpressure with out_ready pattern 1,0,0,1
        pat = 4'b1001;
        load(7'd3, 7'd9, 3'd2, 7'b0000101);
        out_ready = 1'b1;
        #1;
        tick;
        in_valid = 1'b0;
        e = 0;
        k = 0;
        while (e < 7 && k < 40) begin
            out_ready = pat[k % 4];
            #1;
            chk($sformatf("stall.k%0d.vld", k), out_valid0, 1);
            chk($sformatf("stall.k%0d.edge", k), out_edge0, e);
            chk($sformatf("stall.k%0d.msg", k), out_msg0, BASIC_E0[8*e +: 8]);
            chk($sformatf("stall.k%0d.in_rdy", k), in_ready0, (out_ready && e == 6));
            if (out_ready) e++;
            tick;
            k++;
        end
        chk("stall.edges_seen", e, 7);
        out_ready = 1'b1;
        #1;
        chk("stall.done_vld", out_valid0, 0);
        tick;

        // Back-to-back records with no bubble
        load(7'd3, 7'd9, 3'd2, 7'b0000101);
        out_ready = 1'b1;
        #1;
        tick;
        load(7'd127, 7'd127, 3'd0, 7'b0000001);
        #1;
        for (int c = 0; c < 14; c++) begin
            exp_msg = (c < 7) ? BASIC_E0 : MAXN_E0;
            chk($sformatf("b2b.c%0d.vld", c), out_valid0, 1);
            chk($sformatf("b2b.c%0d.edge", c), out_edge0, c % 7);
            chk($sformatf("b2b.c%0d.msg", c), out_msg0, exp_msg[8*(c % 7) +: 8]);
            chk($sformatf("b2b.c%0d.last", c), out_last0, (c % 7 == 6));
            chk($sformatf("b2b.c%0d.in_rdy", c), in_ready0, (c % 7 == 6));
            tick;
            if (c == 6) in_valid = 1'b0;
        end
        chk("b2b.done_vld", out_valid0, 0);
        tick;

        // Reset asserted during edge 3
        load(7'd3, 7'd9, 3'd2, 7'b0000101);
        out_ready = 1'b1;
        #1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        chk("midrst.edge3", out_edge0, 3);
        rst = 1'b1;
        #1;
        chk("midrst.rdy_in_rst", in_ready0, 0);
        tick;
        chk("midrst.vld", out_valid0, 0);
        chk("midrst.msg", out_msg0, 0);
        chk("midrst.edge", out_edge0, 0);
        chk("midrst.last", out_last0, 0);
        rst = 1'b0;
        #1;
        chk("midrst.rdy_after", in_ready0, 1);
        run_record("fresh", 7'd4, 7'd50, 3'd7, 7'b0000010, IDX7_E0, IDX7_E2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
